// File: rtl/audio_pkg.sv
//==============================================================================
// Module   : audio_pkg
// Desc     : Shared constants and sample-format helpers for the audio datapath
//            (sample player, sample FIFO, PWM modulator).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package audio_pkg;

    // Width of one signed PCM audio sample
    localparam int SAMPLE_W = 16;

    // 100 MHz clocks per 44.1 kHz sample period (100e6 / 2268 = 44.09 kHz)
    localparam int DIV_SAMPLE_44K1 = 2268;

    // Offset-binary code of a zero (silent) sample
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

    // Two's-complement sample to offset binary: flipping the sign bit maps
    // -32768..32767 onto 0..65535 so the value can drive a duty cycle directly
    function automatic logic [SAMPLE_W-1:0] to_offset(input logic [SAMPLE_W-1:0] sample);
        return {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/audio_pwm_modulator_if.sv
//==============================================================================
// Module   : audio_pwm_modulator_if
// Desc     : Valid/ready sample stream from the sample player into the
//            PWM modulator. Master drives data/valid, slave drives ready.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface audio_pwm_modulator_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] Sample_Data;
    logic                Sample_Valid;
    logic                Sample_Ready;

    modport master (
        output Sample_Data,
        output Sample_Valid,
        input  Sample_Ready
    );

    modport slave (
        input  Sample_Data,
        input  Sample_Valid,
        output Sample_Ready
    );

endinterface

`default_nettype wire

// File: rtl/audio_sample_fifo.sv
//==============================================================================
// Module   : audio_sample_fifo
// Desc     : Small synchronous FIFO with push/pop, full/empty flags and an
//            occupancy count. DEPTH must be a power of two >= 2. Pushes while
//            full and pops while empty are ignored. Reusable by the reader.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module audio_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] c_level_full = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == c_level_full);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop  & ~o_empty;

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/audio_pwm_modulator.sv
//==============================================================================
// Module   : audio_pwm_modulator
// Desc     : Buffers signed 16-bit samples from a valid/ready stream, releases
//            one per sample period and drives AUD_PWM/AUD_SD. Default build uses
//            a PWM comparator whose duty only changes at period boundaries.
//            Define AUD_SDELTA_EN to replace the comparator with a first-order
//            sigma-delta modulator at full 16-bit resolution.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module audio_pwm_modulator
    import audio_pkg::*;
#(
    parameter int DIV_SAMPLE = DIV_SAMPLE_44K1,
    parameter int PWM_BITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clock_100MHz,
    input  logic                          Clear_n,
    input  logic                          Enable,
    audio_pwm_modulator_if.slave          smp,
    output logic                          AUD_PWM,
    output logic                          AUD_SD,
    output logic                          Underrun,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level
);

    localparam int SDIV_W = $clog2(DIV_SAMPLE);
    localparam logic [SDIV_W-1:0] c_sdiv_last = SDIV_W'(DIV_SAMPLE - 1);

    logic                  r_run;
    logic [SDIV_W-1:0]     r_sdiv;
    logic                  w_strobe;
    logic [SAMPLE_W-1:0]   r_cur_sample;
    logic                  r_underrun;
    logic                  r_sd;
    logic                  r_pwm;
    logic [SAMPLE_W-1:0]   w_offset;
    logic [SAMPLE_W-1:0]   w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;

    // Ready depends only on registered state, never on Sample_Valid
    assign smp.Sample_Ready = r_run & ~w_fifo_full;
    assign w_push           = smp.Sample_Valid & smp.Sample_Ready;
    assign w_strobe         = Enable & (r_sdiv == c_sdiv_last);
    assign w_offset         = to_offset(r_cur_sample);

    assign AUD_PWM  = r_pwm;
    assign AUD_SD   = r_sd;
    assign Underrun = r_underrun;

    audio_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clock_100MHz),
        .rst_n   (Clear_n),
        .i_push  (w_push),
        .i_wdata (smp.Sample_Data),
        .i_pop   (w_strobe),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (Fifo_Level)
    );

    // Holds Sample_Ready low during reset, raising it on the first edge after release
    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    // Sample-period divider, parked at zero while playback is disabled
    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n)                r_sdiv <= '0;
        else if (!Enable)            r_sdiv <= '0;
        else if (r_sdiv == c_sdiv_last) r_sdiv <= '0;
        else                         r_sdiv <= r_sdiv + SDIV_W'(1);
    end

    // On each strobe take the FIFO head, or silence plus a sticky underrun if empty
    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n) begin
            r_cur_sample <= '0;
            r_underrun   <= 1'b0;
        end else if (w_strobe) begin
            if (w_fifo_empty) begin
                r_cur_sample <= '0;
                r_underrun   <= 1'b1;
            end else begin
                r_cur_sample <= w_fifo_head;
            end
        end
    end

    // Amplifier shutdown_n follows Enable one cycle late
    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n) r_sd <= 1'b0;
        else          r_sd <= Enable;
    end

`ifdef AUD_SDELTA_EN

    logic [SAMPLE_W:0] r_acc;

    // First-order sigma-delta: the accumulator carry is the 1-bit output density
    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n) begin
            r_acc <= '0;
            r_pwm <= 1'b0;
        end else if (!Enable) begin
            r_acc <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_acc <= {1'b0, r_acc[SAMPLE_W-1:0]} + {1'b0, w_offset};
            r_pwm <= r_acc[SAMPLE_W];
        end
    end

`else

    localparam logic [PWM_BITS-1:0] c_pcnt_last = '1;
    localparam logic [PWM_BITS-1:0] c_duty_mid  = MIDSCALE[SAMPLE_W-1 -: PWM_BITS];

    logic [PWM_BITS-1:0] r_pcnt;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_next_duty;

    // Truncate the offset sample to the PWM resolution (no rounding)
    assign w_next_duty = w_offset[SAMPLE_W-1 -: PWM_BITS];

    // PWM period counter, parked at zero while playback is disabled
    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n)     r_pcnt <= '0;
        else if (!Enable) r_pcnt <= '0;
        else              r_pcnt <= r_pcnt + PWM_BITS'(1);
    end

    // Duty reloads only as the counter wraps, so no period is ever split
    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n)                               r_duty <= c_duty_mid;
        else if (Enable && (r_pcnt == c_pcnt_last)) r_duty <= w_next_duty;
    end

    // Registered comparator output keeps AUD_PWM glitch-free
    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n) r_pwm <= 1'b0;
        else          r_pwm <= Enable & (r_pcnt < r_duty);
    end

`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_pwm_modulator.sv
//==============================================================================
// Module   : tb_audio_pwm_modulator
// Desc     : Directed bench for audio_pwm_modulator with a short sample period
//            (DIV_SAMPLE=512, PWM_BITS=8, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_audio_pwm_modulator;

    localparam int DIV  = 512;
    localparam int PB   = 8;
    localparam int FD   = 4;
    localparam int NWIN = 19;
    localparam int NCYC = 4964;

    logic       clk     = 1'b0;
    logic       clear_n = 1'b0;
    logic       enable  = 1'b0;
    logic       aud_pwm;
    logic       aud_sd;
    logic       underrun;
    logic [2:0] level;

    int n_checks = 0;
    int n_errors = 0;
    int hi     [NWIN];
    int exp_hi [NWIN] = '{128, 128, 128, 128, 128, 144, 144, 160, 160, 176,
                          176, 192, 192, 255, 255,   0,   0, 128, 128};

    audio_pwm_modulator_if smp_if ();

    audio_pwm_modulator #(
        .DIV_SAMPLE (DIV),
        .PWM_BITS   (PB),
        .FIFO_DEPTH (FD)
    ) dut (
        .Clock_100MHz (clk),
        .Clear_n      (clear_n),
        .Enable       (enable),
        .smp          (smp_if),
        .AUD_PWM      (aud_pwm),
        .AUD_SD       (aud_sd),
        .Underrun     (underrun),
        .Fifo_Level   (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    initial begin
        smp_if.Sample_Valid = 1'b0;
        smp_if.Sample_Data  = 16'h0000;
        for (int i = 0; i < NWIN; i++) hi[i] = 0;

        // Reset / idle
        #100;
        check("rst_pwm",   32'(aud_pwm),             0);
        check("rst_sd",    32'(aud_sd),              0);
        check("rst_undr",  32'(underrun),            0);
        check("rst_level", 32'(level),               0);
        check("rst_ready", 32'(smp_if.Sample_Ready), 0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(smp_if.Sample_Ready), 1);
        check("idle_level", 32'(level),               0);

        // Fill with playback disabled, fifth sample held off by backpressure
        smp_if.Sample_Valid = 1'b1;
        smp_if.Sample_Data  = 16'h0000;
        @(negedge clk); smp_if.Sample_Data = 16'h1000;
        @(negedge clk); smp_if.Sample_Data = 16'h2000;
        @(negedge clk); smp_if.Sample_Data = 16'h3000;
        @(negedge clk); smp_if.Sample_Data = 16'h4000;
        check("fill_level", 32'(level),               4);
        check("fill_ready", 32'(smp_if.Sample_Ready), 0);
        repeat (3) @(negedge clk);
        check("held_level", 32'(level),   4);
        check("held_pwm",   32'(aud_pwm), 0);
        check("held_sd",    32'(aud_sd),  0);

        // Playback: k counts clock edges since Enable rose
        enable = 1'b1;
        for (int k = 1; k <= NCYC; k++) begin
            @(negedge clk);
            if (k <= NWIN * 256) hi[(k - 1) / 256] += int'(aud_pwm);
            case (k)
                1:    check("sd_on", 32'(aud_sd), 1);
                511:  begin
                          check("pre_strobe_level", 32'(level),               4);
                          check("pre_strobe_ready", 32'(smp_if.Sample_Ready), 0);
                      end
                512:  begin
                          check("coll_level",  32'(level),               3);
                          check("coll_ready",  32'(smp_if.Sample_Ready), 1);
                          check("coll_undr",   32'(underrun),            0);
                      end
                513:  begin
                          check("coll_refill", 32'(level), 4);
                          smp_if.Sample_Valid = 1'b0;
                      end
                1024: begin
                          check("pop2_level", 32'(level), 3);
                          smp_if.Sample_Valid = 1'b1;
                          smp_if.Sample_Data  = 16'h7FFF;
                      end
                1025: begin
                          check("push7fff_level", 32'(level), 4);
                          smp_if.Sample_Data = 16'h8000;
                      end
                1536: check("pop3_level", 32'(level), 3);
                1537: begin
                          check("push8000_level", 32'(level), 4);
                          smp_if.Sample_Valid = 1'b0;
                      end
                4095: begin
                          check("drained_level", 32'(level),    0);
                          check("pre_undr",      32'(underrun), 0);
                      end
                4096: check("undr_set", 32'(underrun), 1);
                4200: begin
                          smp_if.Sample_Valid = 1'b1;
                          smp_if.Sample_Data  = 16'h4800;
                      end
                4201: begin
                          smp_if.Sample_Valid = 1'b0;
                          check("post_undr_level", 32'(level), 1);
                      end
                4300: check("undr_sticky", 32'(underrun), 1);
                4608: check("pop4800_level", 32'(level), 0);
                4700: begin
                          smp_if.Sample_Valid = 1'b1;
                          smp_if.Sample_Data  = 16'h1111;
                      end
                4701: begin
                          smp_if.Sample_Valid = 1'b0;
                          check("push1111_level", 32'(level), 1);
                      end
                default: ;
            endcase
        end

        // High clocks per PWM period, in FIFO order
        for (int m = 0; m < NWIN; m++) check($sformatf("hi_win%0d", m), 32'(hi[m]), 32'(exp_hi[m]));

        // Duty 200, pcnt 100: output is high, then reset drops it with no clock edge
        check("pre_rst_pwm", 32'(aud_pwm), 1);
        clear_n = 1'b0;
        #1;
        check("async_pwm",   32'(aud_pwm),             0);
        check("async_sd",    32'(aud_sd),              0);
        check("async_level", 32'(level),               0);
        check("async_ready", 32'(smp_if.Sample_Ready), 0);
        check("async_undr",  32'(underrun),            0);
        enable = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("rel_level", 32'(level),               0);
        check("rel_ready", 32'(smp_if.Sample_Ready), 1);
        check("rel_pwm",   32'(aud_pwm),             0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/audio_pwm_modulator.md
Name: audio_pwm_modulator

Overview:
- Downstream stage of the readmemh sample player: accepts 16-bit two's-complement audio samples over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per 44.1 kHz sample period and drives the board audio pins AUD_PWM/AUD_SD with a glitch-free PWM.
- The upstream ROM reader streams Address/Data into this block instead of producing PWM itself.

Parameters:
- DIV_SAMPLE, 2268: Clock_100MHz cycles per sample period (100 MHz / 2268 ≈ 44.09 kHz).
- PWM_BITS, 8: PWM resolution; PWM period = 2^PWM_BITS clocks.
- FIFO_DEPTH, 4: sample buffer entries; power of two, ≥ 2.

Ports:
- Clock_100MHz  input  1  system clock.
- Clear_n  input  1  asynchronous active-low reset.
- Enable  input  1  playback enable.
- Sample_Data  input  16  signed sample from upstream.
- Sample_Valid  input  1  Sample_Data valid.
- Sample_Ready  output  1  FIFO can accept.
- AUD_PWM  output  1  PWM audio output.
- AUD_SD  output  1  amplifier shutdown_n; 1 = amplifier on.
- Underrun  output  1  sticky flag: a sample strobe found the FIFO empty.
- Fifo_Level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: one clock Clock_100MHz; reset Clear_n is asynchronous, active-low. While Clear_n=0, all state clears: FIFO empty, counters 0, duty = mid-scale 2^(PWM_BITS-1), AUD_PWM=0, AUD_SD=0, Underrun=0, Fifo_Level=0, Sample_Ready=0. Sample_Ready rises in the first cycle after release.
- Handshake:
  - Push occurs on a rising edge with Sample_Valid & Sample_Ready.
  - Sample_Ready = !full, registered-equivalent (no combinational path from Sample_Valid).
  - Upstream must hold data while Valid=1 and Ready=0.
- Sample pacing:
  - sdiv counts 0..DIV_SAMPLE-1 while Enable=1.
  - strobe = (sdiv == DIV_SAMPLE-1).
  - On strobe: pop the FIFO head into cur_sample. If the FIFO is empty, cur_sample = 0 and Underrun sets (sticky until reset).
- Simultaneous push and pop: the level stays the same, both operate. A pop on a full FIFO frees Sample_Ready on the next cycle only.
- Conversion: offset = {~cur_sample[15], cur_sample[14:0]}; next_duty = offset[15 -: PWM_BITS] (truncation, no rounding).
- PWM:
  - pcnt counts 0..2^PWM_BITS-1 while Enable=1.
  - duty is loaded from next_duty only when pcnt wraps to 0, so a period never changes mid-cycle.
  - AUD_PWM registered = (pcnt < duty). duty=0 → constant 0; max duty = 2^PWM_BITS-1 (never 100%).
- Latency:
  - The first pushed sample is popped at the first strobe, DIV_SAMPLE cycles after Enable rises.
  - It appears on AUD_PWM from the next pcnt wrap, plus one register stage.
- Enable=0:
  - sdiv and pcnt are held at 0; AUD_PWM=0; AUD_SD=0.
  - FIFO keeps its contents and still accepts pushes; duty is retained.
  - AUD_SD = Enable registered, one cycle late.
- Reset mid-operation aborts immediately. No partial PWM period is completed.

Optional Feature:
- AUD_SDELTA_EN defined: AUD_PWM is driven by a first-order sigma-delta modulator instead of the comparator.
  - 17-bit accumulator: acc <= acc[15:0] + offset every clock while Enable=1.
  - AUD_PWM = registered carry acc[16].
  - Full 16-bit resolution; pcnt and duty are unused.
  - Accumulator resets to 0 and holds while Enable=0.
- Not defined: PWM comparator as above.
- Ports and handshake are identical in both builds.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W=16.
  - DIV_SAMPLE_44K1=2268.
  - MIDSCALE constant.
  - signed-to-offset conversion function.
- Sub-module audio_sample_fifo: parameterised synchronous FIFO with push/pop/full/empty/level. It is reusable by the upstream reader.

Test Plan:
- Reset/idle: Clear_n=0 for 100 ns, Enable=0 → all outputs 0; Sample_Ready=1 after release; Fifo_Level=0.
- Fill/backpressure: push 0x0000, 0x1000, 0x2000, 0x3000 back-to-back with Enable=0 → Fifo_Level=4, Sample_Ready=0; a 5th Valid is held and not accepted.
- Duty mapping (DIV_SAMPLE=512, PWM_BITS=8):
  - sample 0x0000 → 128 high clocks per 256.
  - 0x7FFF → 255 high.
  - 0x8000 → AUD_PWM stays 0 for the full period.
- Underrun: Enable=1 with empty FIFO → Underrun=1 at first strobe; duty = 128; flag stays 1 after later pushes.
- Pop/push collision: FIFO full, Valid held with 0x4000, strobe occurs → Level 4→3, Ready=1 the next cycle, 0x4000 accepted and Level=4 again; no sample lost or duplicated (checked by output order).
- Async reset mid-period at pcnt=100 with duty=200 → AUD_PWM falls without waiting for a clock edge; FIFO is empty after release.
